// File: rtl/stdev_threshold_detector.sv
// Threshold alarm for the stdev filter output: high/low hysteresis with a
// debounce streak, a rising-edge pulse, a saturating entry counter and a peak-hold.
module stdev_threshold_detector #(
   parameter int WIDTH          = 14,
   parameter int DEBOUNCE_WIDTH = 8,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          stdev_in,
   input  logic                      stdev_valid,
   input  logic [WIDTH-1:0]          thresh_high,
   input  logic [WIDTH-1:0]          thresh_low,
   input  logic [DEBOUNCE_WIDTH-1:0] debounce_len,
   input  logic                      clear_peak,
   output logic                      alarm,
   output logic                      alarm_rise,
   output logic [COUNT_WIDTH-1:0]    event_count,
   output logic [WIDTH-1:0]          peak_stdev
);

   // state     | meaning
   // IDLE      | alarm off, no qualifying high samples seen
   // ARMING    | alarm off, counting consecutive samples above thresh_high
   // ACTIVE    | alarm on, no qualifying low samples seen
   // RELEASING | alarm on, counting consecutive samples below thresh_low
   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ARMING    = 2'd1,
      S_ACTIVE    = 2'd2,
      S_RELEASING = 2'd3
   } state_t;

   state_t                    state, state_nxt;
   logic [DEBOUNCE_WIDTH-1:0] streak, streak_nxt;
   logic [DEBOUNCE_WIDTH:0]   streak_inc;
   logic [DEBOUNCE_WIDTH:0]   n_len;
   logic                      hi_q, lo_q, n_is_one, streak_done;
   logic                      alarm_nxt, rise_nxt;

   assign hi_q        = stdev_in > thresh_high;
   assign lo_q        = stdev_in < thresh_low;
   assign n_len       = (debounce_len == '0) ? (DEBOUNCE_WIDTH+1)'(1) : {1'b0, debounce_len};
   assign n_is_one    = n_len == (DEBOUNCE_WIDTH+1)'(1);
   assign streak_inc  = {1'b0, streak} + (DEBOUNCE_WIDTH+1)'(1);
   // >= so that shrinking debounce_len mid-streak still completes the transition
   assign streak_done = streak_inc >= n_len;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= S_IDLE;
         streak <= '0;
      end else begin
         state  <= state_nxt;
         streak <= streak_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      streak_nxt = streak;
      if (stdev_valid) begin
         case (state)
            S_IDLE: begin
               if (hi_q) begin
                  if (n_is_one) begin
                     state_nxt = S_ACTIVE;
                  end else begin
                     state_nxt  = S_ARMING;
                     streak_nxt = DEBOUNCE_WIDTH'(1);
                  end
               end
            end
            S_ARMING: begin
               if (hi_q) begin
                  if (streak_done) begin
                     state_nxt  = S_ACTIVE;
                     streak_nxt = '0;
                  end else begin
                     streak_nxt = streak_inc[DEBOUNCE_WIDTH-1:0];
                  end
               end else begin
                  state_nxt  = S_IDLE;
                  streak_nxt = '0;
               end
            end
            S_ACTIVE: begin
               if (lo_q) begin
                  if (n_is_one) begin
                     state_nxt = S_IDLE;
                  end else begin
                     state_nxt  = S_RELEASING;
                     streak_nxt = DEBOUNCE_WIDTH'(1);
                  end
               end
            end
            S_RELEASING: begin
               if (lo_q) begin
                  if (streak_done) begin
                     state_nxt  = S_IDLE;
                     streak_nxt = '0;
                  end else begin
                     streak_nxt = streak_inc[DEBOUNCE_WIDTH-1:0];
                  end
               end else begin
                  state_nxt  = S_ACTIVE;
                  streak_nxt = '0;
               end
            end
            default: begin
               state_nxt  = S_IDLE;
               streak_nxt = '0;
            end
         endcase
      end
   end

   always_comb begin
      alarm_nxt = (state_nxt == S_ACTIVE) || (state_nxt == S_RELEASING);
      rise_nxt  = (state_nxt == S_ACTIVE) && ((state == S_IDLE) || (state == S_ARMING));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         alarm       <= 1'b0;
         alarm_rise  <= 1'b0;
         event_count <= '0;
         peak_stdev  <= '0;
      end else begin
         alarm      <= alarm_nxt;
         alarm_rise <= rise_nxt;
         if (rise_nxt && (event_count != '1)) begin
            event_count <= event_count + COUNT_WIDTH'(1);
         end
         if (clear_peak) begin
            peak_stdev <= stdev_valid ? stdev_in : '0;
         end else if (stdev_valid && (stdev_in > peak_stdev)) begin
            peak_stdev <= stdev_in;
         end
      end
   end

endmodule

// File: tb/tb_stdev_threshold_detector.sv
// Bench for stdev_threshold_detector: directed scenarios with literal expectations,
// then random traffic, all cross-checked every cycle against a behavioural model.
module tb_stdev_threshold_detector;

   localparam int WIDTH = 14;
   localparam int DW    = 8;
   localparam int CW    = 6;
   localparam int CMAX  = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] stdev_in;
   logic             stdev_valid;
   logic [WIDTH-1:0] thresh_high;
   logic [WIDTH-1:0] thresh_low;
   logic [DW-1:0]    debounce_len;
   logic             clear_peak;
   logic             alarm;
   logic             alarm_rise;
   logic [CW-1:0]    event_count;
   logic [WIDTH-1:0] peak_stdev;

   int tests = 0;
   int fails = 0;
   bit started = 1'b0;

   // model: alarm flag plus a run length of qualifying samples
   int m_alarm = 0, m_rise = 0, m_count = 0, m_peak = 0, m_run = 0;

   stdev_threshold_detector #(.WIDTH(WIDTH), .DEBOUNCE_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .stdev_in(stdev_in), .stdev_valid(stdev_valid),
      .thresh_high(thresh_high), .thresh_low(thresh_low), .debounce_len(debounce_len),
      .clear_peak(clear_peak), .alarm(alarm), .alarm_rise(alarm_rise),
      .event_count(event_count), .peak_stdev(peak_stdev)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      int n, v;
      if (!reset) begin
         m_alarm = 0; m_rise = 0; m_count = 0; m_peak = 0; m_run = 0;
      end else begin
         v = int'(stdev_in);
         m_rise = 0;
         if (clear_peak) m_peak = stdev_valid ? v : 0;
         else if (stdev_valid && v > m_peak) m_peak = v;
         if (stdev_valid) begin
            n = (debounce_len == 0) ? 1 : int'(debounce_len);
            if (m_alarm == 0) begin
               if (v > int'(thresh_high)) begin
                  m_run++;
                  if (m_run >= n) begin
                     m_alarm = 1; m_run = 0; m_rise = 1;
                     if (m_count < CMAX) m_count++;
                  end
               end else m_run = 0;
            end else begin
               if (v < int'(thresh_low)) begin
                  m_run++;
                  if (m_run >= n) begin
                     m_alarm = 0; m_run = 0;
                  end
               end else m_run = 0;
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // pins both the DUT and the model to a hand-computed value
   task automatic lit(input string name, input int act, input int mdl, input int exp);
      check({name, "_dut"}, act, exp);
      check({name, "_model"}, mdl, exp);
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("cmp_alarm", int'(alarm), m_alarm);
         check("cmp_rise", int'(alarm_rise), m_rise);
         check("cmp_count", int'(event_count), m_count);
         check("cmp_peak", int'(peak_stdev), m_peak);
      end
   end

   task automatic send(input int v, input bit vld, input bit clr = 1'b0);
      @(negedge clk);
      stdev_in    = WIDTH'(v);
      stdev_valid = vld;
      clear_peak  = clr;
   endtask

   task automatic idle();
      send(0, 1'b0);
   endtask

   task automatic cfg(input int n, input int hi, input int lo);
      debounce_len = DW'(n);
      thresh_high  = WIDTH'(hi);
      thresh_low   = WIDTH'(lo);
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      reset = 1'b0; stdev_valid = 1'b0; clear_peak = 1'b0;
      @(negedge clk);
      lit({name, "_alarm"}, int'(alarm), m_alarm, 0);
      lit({name, "_rise"}, int'(alarm_rise), m_rise, 0);
      lit({name, "_count"}, int'(event_count), m_count, 0);
      lit({name, "_peak"}, int'(peak_stdev), m_peak, 0);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; stdev_in = '0; stdev_valid = 1'b0; clear_peak = 1'b0;
      cfg(3, 100, 50);
      @(negedge clk);
      @(negedge clk);
      started = 1'b1;
      do_reset("rst0");

      // scenario 1: three highs arm the alarm
      send(120, 1); send(130, 1);
      idle();
      lit("t1_no_alarm_yet", int'(alarm), m_alarm, 0);
      send(140, 1); idle();
      lit("t1_alarm", int'(alarm), m_alarm, 1);
      lit("t1_rise", int'(alarm_rise), m_rise, 1);
      lit("t1_count", int'(event_count), m_count, 1);
      idle();
      lit("t1_rise_drop", int'(alarm_rise), m_rise, 0);

      // scenario 3: interrupted release, then full release
      send(40, 1); send(40, 1); send(60, 1); idle();
      lit("t3_hold", int'(alarm), m_alarm, 1);
      lit("t3_no_rise", int'(alarm_rise), m_rise, 0);
      send(40, 1); send(40, 1); idle();
      lit("t3_still_on", int'(alarm), m_alarm, 1);
      send(40, 1); idle();
      lit("t3_release", int'(alarm), m_alarm, 0);
      lit("t3_count", int'(event_count), m_count, 1);

      // scenario 2: broken streak restarts
      send(120, 1); send(130, 1); send(90, 1); send(120, 1); idle();
      lit("t2_alarm", int'(alarm), m_alarm, 0);
      lit("t2_count", int'(event_count), m_count, 1);
      send(125, 1); idle();
      lit("t2_partial", int'(alarm), m_alarm, 0);
      send(125, 1); idle();
      lit("t2_armed", int'(alarm), m_alarm, 1);
      lit("t2_count2", int'(event_count), m_count, 2);

      // scenario 4: debounce_len 0 behaves as 1; invalid cycles ignored
      do_reset("rst4");
      cfg(0, 10, 5);
      send(11, 1); idle();
      lit("t4_alarm", int'(alarm), m_alarm, 1);
      lit("t4_rise", int'(alarm_rise), m_rise, 1);
      send(11, 0); send(0, 0); send(11, 0); send(0, 0); idle();
      lit("t4_alarm_hold", int'(alarm), m_alarm, 1);
      lit("t4_count", int'(event_count), m_count, 1);

      // scenario 5: peak hold and clear
      do_reset("rst5");
      cfg(3, 1000, 0);
      send(5, 1); send(200, 1); send(17, 1); send(300, 0); idle();
      lit("t5_peak", int'(peak_stdev), m_peak, 200);
      send(9, 1, 1'b1); idle();
      lit("t5_clear_valid", int'(peak_stdev), m_peak, 9);
      send(50, 0, 1'b1); idle();
      lit("t5_clear_invalid", int'(peak_stdev), m_peak, 0);

      // scenario 6: reset mid-arming, mid-active, then counter saturation
      do_reset("rst6a");
      cfg(3, 100, 50);
      send(120, 1); send(130, 1);
      do_reset("t6_mid_arming");
      send(120, 1); send(120, 1); idle();
      lit("t6_restart", int'(alarm), m_alarm, 0);
      cfg(1, 100, 50);
      send(120, 1); send(10, 1); send(120, 1); send(10, 1); send(120, 1); idle();
      lit("t6_active", int'(alarm), m_alarm, 1);
      lit("t6_count3", int'(event_count), m_count, 3);
      do_reset("t6_mid_active");
      for (int i = 0; i < CMAX + 6; i++) begin
         send(120, 1); send(10, 1);
      end
      send(120, 1); idle();
      lit("t6_sat", int'(event_count), m_count, CMAX);
      lit("t6_sat_rise", int'(alarm_rise), m_rise, 1);

      // random traffic against the model
      do_reset("rst_rand");
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (i % 150 == 0) cfg($urandom_range(0, 4), $urandom_range(40, 120), $urandom_range(20, 100));
         else if ($urandom_range(0, 60) == 0) debounce_len = DW'($urandom_range(0, 4));
         stdev_in    = WIDTH'($urandom_range(0, 160));
         stdev_valid = ($urandom_range(0, 3) != 0);
         clear_peak  = ($urandom_range(0, 49) == 0);
         reset       = ($urandom_range(0, 399) != 0);
      end
      @(negedge clk);
      reset = 1'b1; stdev_valid = 1'b0; clear_peak = 1'b0;
      @(negedge clk);
      @(negedge clk);
      started = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
